// File: rtl/buffer_arbiter_pkg.sv
// Shared types and constants for the buffer arbiter and its round-robin sub-arbiters.
package buffer_arbiter_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t PUSH_WAIT = 3'd1;
    localparam state_t POP_WAIT  = 3'd2;
    localparam state_t DELIVER   = 3'd3;
    localparam state_t RELEASE   = 3'd4;

    typedef logic prio_t;

    localparam prio_t PRIO_PUSH = 1'b0;
    localparam prio_t PRIO_POP  = 1'b1;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buffer_arbiter_rr.sv
// Round-robin arbiter: searches upward from its pointer, pointer moves past the winner on advance.
module rr_arbiter
    import buffer_arbiter_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] probe;
    logic          found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        probe     = '0;
        for (int i = 0; i < int'(N); i++) begin
            probe = IW'((int'(ptr_q) + i) % int'(N));
            if (!found && req[probe]) begin
                found     = 1'b1;
                grant_idx = probe;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_q <= '0;
        end else if (advance && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Shares one buffer between several producers and consumers with round-robin arbitration,
// push/pop priority alternation and a watchdog on every buffer wait state.
module buffer_arbiter
    import buffer_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PROD   = 2,
    parameter int unsigned NUM_CONS   = 2,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PROD-1:0]            prod_req,
    input  logic [NUM_PROD*DATA_WIDTH-1:0] prod_data,
    output logic [NUM_PROD-1:0]            prod_grant,
    input  logic [NUM_CONS-1:0]            cons_req,
    output logic [NUM_CONS-1:0]            cons_valid,
    input  logic [NUM_CONS-1:0]            cons_ack,
    output logic [DATA_WIDTH-1:0]          cons_data,
    output logic                           buf_push,
    output logic                           buf_pop,
    output logic                           buf_pop_ack,
    output logic [DATA_WIDTH-1:0]          buf_data_in,
    input  logic [DATA_WIDTH-1:0]          buf_data_out,
    input  logic                           buf_is_ready,
    input  logic                           buf_is_done,
    input  logic                           buf_is_full,
    input  logic                           buf_is_empty,
    output logic                           timeout_err
);

    localparam int unsigned PW = idx_width(NUM_PROD);
    localparam int unsigned CW = idx_width(NUM_CONS);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    state_t                state_q, state_d;
    prio_t                 prio_q, prio_d;
    logic [CW-1:0]         cons_idx_q, cons_idx_d;
    logic [DATA_WIDTH-1:0] cons_data_q, cons_data_d;
    logic [WW-1:0]         wdog_q, wdog_d;
    logic                  timeout_q, timeout_d;

    logic [NUM_PROD-1:0] p_grant;
    logic [PW-1:0]       p_idx;
    logic [NUM_CONS-1:0] c_grant;
    logic [CW-1:0]       c_idx;
    logic                push_elig, pop_elig;
    logic                do_push, do_pop;
    logic                in_wait;

    rr_arbiter #(
        .N (NUM_PROD)
    ) u_prod_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (prod_req),
        .advance   (do_push),
        .grant     (p_grant),
        .grant_idx (p_idx)
    );

    rr_arbiter #(
        .N (NUM_CONS)
    ) u_cons_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (cons_req),
        .advance   (do_pop),
        .grant     (c_grant),
        .grant_idx (c_idx)
    );

    assign push_elig = |p_grant & ~buf_is_full;
    assign pop_elig  = |c_grant & ~buf_is_empty;
    assign in_wait   = (state_q == PUSH_WAIT) || (state_q == POP_WAIT) || (state_q == RELEASE);

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cons_idx_d  = cons_idx_q;
        cons_data_d = cons_data_q;
        wdog_d      = wdog_q;
        timeout_d   = 1'b0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        buf_pop_ack = 1'b0;

        case (state_q)
            IDLE: begin
                if (buf_is_ready) begin
                    if (push_elig && (!pop_elig || prio_q == PRIO_PUSH)) begin
                        do_push = 1'b1;
                        state_d = PUSH_WAIT;
                    end else if (pop_elig) begin
                        do_pop      = 1'b1;
                        buf_pop_ack = 1'b1;
                        cons_idx_d  = c_idx;
                        state_d     = POP_WAIT;
                    end
                    if (push_elig && pop_elig) begin
                        prio_d = ~prio_q;
                    end
                end
            end
            PUSH_WAIT: begin
                if (buf_is_ready) begin
                    state_d = IDLE;
                end
            end
            POP_WAIT: begin
                buf_pop_ack = 1'b1;
                if (buf_is_done) begin
                    cons_data_d = buf_data_out;
                    state_d     = DELIVER;
                end
            end
            DELIVER: begin
                // Keeping pop_ack high makes the buffer hold DONE until the consumer takes the word.
                buf_pop_ack = 1'b1;
                if (cons_ack[cons_idx_q]) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (buf_is_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (in_wait) begin
            if (wdog_q + WW'(1) == WW'(TIMEOUT)) begin
                wdog_d    = '0;
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end

        // A transfer cannot start or continue while reset is held.
        if (rst_n) begin
            do_push     = 1'b0;
            do_pop      = 1'b0;
            buf_pop_ack = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            prio_q      <= PRIO_PUSH;
            cons_idx_q  <= '0;
            cons_data_q <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cons_idx_q  <= cons_idx_d;
            cons_data_q <= cons_data_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        cons_valid = '0;
        if (state_q == DELIVER && !rst_n) begin
            cons_valid[cons_idx_q] = 1'b1;
        end
    end

    assign prod_grant  = do_push ? p_grant : '0;
    assign buf_push    = do_push;
    assign buf_pop     = do_pop;
    assign buf_data_in = do_push ? prod_data[p_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign cons_data   = cons_data_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter: a cycle-by-cycle vector table plus hand-written corner cases.
module tb_buffer_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  prod_req;
    logic [15:0] prod_data;
    logic [1:0]  prod_grant;
    logic [1:0]  cons_req;
    logic [1:0]  cons_valid;
    logic [1:0]  cons_ack;
    logic [7:0]  cons_data;
    logic        buf_push, buf_pop, buf_pop_ack;
    logic [7:0]  buf_data_in;
    logic [7:0]  buf_data_out;
    logic        buf_is_ready, buf_is_done, buf_is_full, buf_is_empty;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    buffer_arbiter #(
        .DATA_WIDTH (8),
        .NUM_PROD   (2),
        .NUM_CONS   (2),
        .TIMEOUT    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .prod_req     (prod_req),
        .prod_data    (prod_data),
        .prod_grant   (prod_grant),
        .cons_req     (cons_req),
        .cons_valid   (cons_valid),
        .cons_ack     (cons_ack),
        .cons_data    (cons_data),
        .buf_push     (buf_push),
        .buf_pop      (buf_pop),
        .buf_pop_ack  (buf_pop_ack),
        .buf_data_in  (buf_data_in),
        .buf_data_out (buf_data_out),
        .buf_is_ready (buf_is_ready),
        .buf_is_done  (buf_is_done),
        .buf_is_full  (buf_is_full),
        .buf_is_empty (buf_is_empty),
        .timeout_err  (timeout_err)
    );

    // ctl = {rst, ready, done, full, empty}; ppa = {push, pop, pop_ack}
    typedef struct {
        logic [4:0]  ctl;
        logic [1:0]  preq;
        logic [15:0] pdata;
        logic [1:0]  creq;
        logic [1:0]  cack;
        logic [7:0]  bdo;
        logic [1:0]  pg;
        logic [1:0]  cv;
        logic [7:0]  cd;
        logic [2:0]  ppa;
        logic [7:0]  bdi;
        logic        terr;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, single push, then a push proving IDLE two cycles later
        vecs[0]  = '{5'b11001, 2'b00, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[1]  = '{5'b01001, 2'b01, 16'h00A5, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 8'h00, 3'b100, 8'hA5, 1'b0};
        vecs[2]  = '{5'b01001, 2'b00, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[3]  = '{5'b01001, 2'b10, 16'h3C00, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 8'h00, 3'b100, 8'h3C, 1'b0};
        // Both producers held: grants alternate 01,10,01,10 never back-to-back
        vecs[4]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[5]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 8'h00, 3'b100, 8'h11, 1'b0};
        vecs[6]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[7]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 8'h00, 3'b100, 8'h22, 1'b0};
        vecs[8]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[9]  = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 8'h00, 3'b100, 8'h11, 1'b0};
        vecs[10] = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        vecs[11] = '{5'b01001, 2'b11, 16'h2211, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 8'h00, 3'b100, 8'h22, 1'b0};
        vecs[12] = '{5'b01001, 2'b00, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b000, 8'h00, 1'b0};
        // Pop to consumer 1 with a 5-cycle ack delay; ack from consumer 0 ignored
        vecs[13] = '{5'b01000, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b011, 8'h00, 1'b0};
        vecs[14] = '{5'b01000, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b00, 8'h00, 3'b001, 8'h00, 1'b0};
        vecs[15] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b00, 8'hA5, 2'b00, 2'b00, 8'h00, 3'b001, 8'h00, 1'b0};
        vecs[16] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[17] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[18] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b01, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[19] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[20] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b00, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[21] = '{5'b01100, 2'b00, 16'h0000, 2'b10, 2'b10, 8'h00, 2'b00, 2'b10, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[22] = '{5'b01000, 2'b00, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'hA5, 3'b000, 8'h00, 1'b0};
        // Both sides pending: push, pop, push, pop
        vecs[23] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b01, 2'b00, 8'hA5, 3'b100, 8'h77, 1'b0};
        vecs[24] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 8'hA5, 3'b000, 8'h00, 1'b0};
        vecs[25] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 8'hA5, 3'b011, 8'h00, 1'b0};
        vecs[26] = '{5'b01100, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h5A, 2'b00, 2'b00, 8'hA5, 3'b001, 8'h00, 1'b0};
        vecs[27] = '{5'b01100, 2'b01, 16'h0077, 2'b01, 2'b01, 8'h5A, 2'b00, 2'b01, 8'h5A, 3'b001, 8'h00, 1'b0};
        vecs[28] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 8'h5A, 3'b000, 8'h00, 1'b0};
        vecs[29] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b01, 2'b00, 8'h5A, 3'b100, 8'h77, 1'b0};
        vecs[30] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 8'h5A, 3'b000, 8'h00, 1'b0};
        vecs[31] = '{5'b01000, 2'b01, 16'h0077, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 8'h5A, 3'b011, 8'h00, 1'b0};
        vecs[32] = '{5'b01100, 2'b01, 16'h0077, 2'b01, 2'b00, 8'hC3, 2'b00, 2'b00, 8'h5A, 3'b001, 8'h00, 1'b0};
        vecs[33] = '{5'b01100, 2'b01, 16'h0077, 2'b01, 2'b01, 8'hC3, 2'b00, 2'b01, 8'hC3, 3'b001, 8'h00, 1'b0};
        vecs[34] = '{5'b01000, 2'b00, 16'h0000, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 8'hC3, 3'b000, 8'h00, 1'b0};

        rst_n        = 1'b1;
        prod_req     = '0;
        prod_data    = '0;
        cons_req     = '0;
        cons_ack     = '0;
        buf_data_out = '0;
        buf_is_ready = 1'b1;
        buf_is_done  = 1'b0;
        buf_is_full  = 1'b0;
        buf_is_empty = 1'b1;
        next_cycle();
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            {rst_n, buf_is_ready, buf_is_done, buf_is_full, buf_is_empty} = vecs[i].ctl;
            prod_req     = vecs[i].preq;
            prod_data    = vecs[i].pdata;
            cons_req     = vecs[i].creq;
            cons_ack     = vecs[i].cack;
            buf_data_out = vecs[i].bdo;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  32'({prod_grant, cons_valid, cons_data, buf_push, buf_pop, buf_pop_ack,
                       buf_data_in, timeout_err}),
                  32'({vecs[i].pg, vecs[i].cv, vecs[i].cd, vecs[i].ppa, vecs[i].bdi,
                       vecs[i].terr}));
            next_cycle();
        end

        // Full buffer blocks the producer for 20 cycles, then grants once full clears
        prod_req     = 2'b01;
        prod_data    = 16'h0042;
        cons_req     = 2'b00;
        buf_is_full  = 1'b1;
        buf_is_empty = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("full_block%0d", k), 32'({prod_grant, buf_push}), 32'h0);
            next_cycle();
        end
        buf_is_full = 1'b0;
        @(negedge clk);
        check("full_release", 32'({prod_grant, buf_push, buf_data_in}), 32'({2'b01, 1'b1, 8'h42}));
        next_cycle();
        prod_req = 2'b00;
        next_cycle();

        // Buffer never signals done: watchdog aborts 8 cycles after POP_WAIT entry
        cons_req     = 2'b10;
        buf_is_empty = 1'b0;
        buf_is_done  = 1'b0;
        @(negedge clk);
        check("to_pop", 32'({buf_pop, buf_pop_ack}), 32'h3);
        next_cycle();
        cons_req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d", k), 32'({buf_pop_ack, timeout_err}), 32'h2);
            next_cycle();
        end
        @(negedge clk);
        check("to_pulse", 32'({timeout_err, buf_pop_ack, buf_pop, buf_push}), 32'h8);
        next_cycle();
        @(negedge clk);
        check("to_clear", 32'({timeout_err, buf_pop_ack}), 32'h0);
        next_cycle();

        // Reset while delivering drops cons_valid and the held word
        cons_req = 2'b01;
        @(negedge clk);
        check("rd_pop", 32'({buf_pop, buf_pop_ack}), 32'h3);
        next_cycle();
        buf_is_done  = 1'b1;
        buf_data_out = 8'h99;
        next_cycle();
        @(negedge clk);
        check("rd_deliver", 32'({cons_valid, cons_data}), 32'({2'b01, 8'h99}));
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rd_rst0", 32'({cons_valid, buf_pop_ack}), 32'h0);
        next_cycle();
        @(negedge clk);
        check("rd_rst1", 32'({cons_valid, cons_data, buf_pop_ack}), 32'h0);
        next_cycle();
        rst_n       = 1'b0;
        cons_req    = 2'b00;
        buf_is_done = 1'b0;
        @(negedge clk);
        check("rd_after", 32'({cons_valid, buf_pop_ack, timeout_err}), 32'h0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
